// File: rtl/print_seq_pkg.sv
// Shared types and defaults for the per-layer print sequencer.
// The SEQ_TIMEOUT_EN macro (set by the including build) enables the motion watchdog in print_layer_seq.
package print_seq_pkg;

  localparam int CLK_PER_US  = 96;
  localparam int TMO_US_DEF  = 20000;
  localparam int LAYER_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    PLAT1,
    PRINT,
    PLAT2,
    DOWN
  } seq_state_e;

endpackage

// File: rtl/seq_us_tick.sv
// Free-running microsecond tick generator with synchronous clear.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module seq_us_tick #(
  parameter int CLK_PER_US = 96
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(CLK_PER_US - 1));

endmodule

// File: rtl/print_layer_seq.sv
// Per-layer print sequencer: UP -> PLAT1 -> PRINT -> PLAT2 -> DOWN for layer_num layers.
// Define SEQ_TIMEOUT_EN to build the motion watchdog (UP/PRINT/DOWN); otherwise fault is tied 0.
module print_layer_seq
  import print_seq_pkg::*;
#(
  parameter int CLK_PER_US = print_seq_pkg::CLK_PER_US,
  parameter int TMO_US     = TMO_US_DEF,
  parameter int LAYER_W    = LAYER_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] layer_num,
  input  logic               up_done,
  input  logic               print_done,
  input  logic               down_done,
  input  logic               ptodown_en,
  output logic               st_req_up,
  output logic               st_req_print,
  output logic               st_req_down,
  output logic               st_platform,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_cnt,
  output logic               job_done,
  output logic               fault
);

  // The watchdog's us counter is 15 bits wide.
  if (TMO_US < 1 || TMO_US > 32767 || CLK_PER_US < 1) begin : g_bad_cfg
    $error("print_layer_seq: TMO_US or CLK_PER_US out of range");
  end

  seq_state_e         state, state_next;
  logic [LAYER_W-1:0] num_q, num_next, cnt_next;
  logic               job_done_next;
  logic               entry;
  logic               first_cyc;
  logic               timeout;

  assign entry = (state_next != state);

`ifdef SEQ_TIMEOUT_EN
  logic        tick;
  logic [14:0] us_cnt;
  logic        timed;
  logic        fault_set, fault_clr, fault_q;

  seq_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (entry),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      us_cnt <= '0;
    end else if (entry) begin
      us_cnt <= '0;
    end else if (tick && (us_cnt != '1)) begin
      us_cnt <= us_cnt + 1'b1;
    end
  end

  assign timed   = (state == UP) || (state == PRINT) || (state == DOWN);
  assign timeout = timed && tick && (us_cnt == 15'(TMO_US - 1));

  // A timed-out motion is the only route back to IDLE that neither aborts nor completes the job.
  assign fault_set = timeout && !abort && (state_next == IDLE) && !job_done_next;
  assign fault_clr = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    num_next      = num_q;
    cnt_next      = layer_cnt;
    job_done_next = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (layer_num != '0) begin
            num_next   = layer_num;
            cnt_next   = '0;
            state_next = UP;
          end else begin
            job_done_next = 1'b1;
          end
        end
      end
      UP: begin
        if (up_done)      state_next = PLAT1;
        else if (timeout) state_next = IDLE;
      end
      // ptodown_en lags st_platform, so its value in the first dwell cycle is stale.
      PLAT1: begin
        if (ptodown_en && !first_cyc) state_next = PRINT;
      end
      PRINT: begin
        if (print_done)   state_next = PLAT2;
        else if (timeout) state_next = IDLE;
      end
      PLAT2: begin
        if (ptodown_en && !first_cyc) state_next = DOWN;
      end
      DOWN: begin
        if (down_done) begin
          cnt_next = layer_cnt + 1'b1;
          if (cnt_next == num_q) begin
            job_done_next = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = UP;
          end
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next    = IDLE;
      num_next      = num_q;
      cnt_next      = layer_cnt;
      job_done_next = 1'b0;
    end
  end

  // Outputs are registered from the next state so strobes land in the new state's first cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      num_q        <= '0;
      layer_cnt    <= '0;
      first_cyc    <= 1'b0;
      st_req_up    <= 1'b0;
      st_req_print <= 1'b0;
      st_req_down  <= 1'b0;
      st_platform  <= 1'b0;
      busy         <= 1'b0;
      job_done     <= 1'b0;
    end else begin
      state        <= state_next;
      num_q        <= num_next;
      layer_cnt    <= cnt_next;
      first_cyc    <= entry;
      st_req_up    <= entry && (state_next == UP);
      st_req_print <= entry && (state_next == PRINT);
      st_req_down  <= entry && (state_next == DOWN);
      st_platform  <= (state_next == PLAT1) || (state_next == PLAT2);
      busy         <= (state_next != IDLE);
      job_done     <= job_done_next;
    end
  end

endmodule

// File: tb/tb_print_layer_seq.sv
// Self-checking bench for print_layer_seq: a responder plays the motion and down-control stages,
// and a monitor reduces the strobes to an event string compared against the expected layer sequence.
`timescale 1ns/1ps
module tb_print_layer_seq;

  localparam int LW  = 16;
  localparam int CPU = 96;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] layer_num = '0;
  logic          up_done = 1'b0, print_done = 1'b0, down_done = 1'b0, ptodown_en = 1'b0;
  logic          st_req_up, st_req_print, st_req_down, st_platform, busy, job_done, fault;
  logic [LW-1:0] layer_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  print_layer_seq #(.CLK_PER_US(CPU), .TMO_US(TMO), .LAYER_W(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .layer_num(layer_num),
    .up_done(up_done), .print_done(print_done), .down_done(down_done), .ptodown_en(ptodown_en),
    .st_req_up(st_req_up), .st_req_print(st_req_print), .st_req_down(st_req_down),
    .st_platform(st_platform), .busy(busy), .layer_cnt(layer_cnt), .job_done(job_done),
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- responder: motion axes + down-control dwell ----------------
  bit resp_en = 0, force_pto = 0, spur = 0, no_up = 0, rand_dly = 0, in_plat2 = 0;
  int dly_fix = 5, dwell = 3;
  int up_c = 0, pr_c = 0, dn_c = 0, dcnt = 0, spur_c = 0, down_drive_cyc = 0;

  function automatic int pick();
    return rand_dly ? int'($urandom_range(1, 6)) : dly_fix;
  endfunction

  always @(negedge clk) begin
    up_done = 0; print_done = 0; down_done = 0;
    if (!resp_en) begin
      up_c = 0; pr_c = 0; dn_c = 0; dcnt = 0; spur_c = 0; in_plat2 = 0;
      ptodown_en = force_pto;
    end else begin
      if (up_c > 0) begin up_c--; if (up_c == 0) up_done = 1; end
      if (pr_c > 0) begin pr_c--; if (pr_c == 0) print_done = 1; end
      if (dn_c > 0) begin dn_c--; if (dn_c == 0) begin down_done = 1; down_drive_cyc = cyc; end end
      if (spur_c > 0) begin spur_c--; if (spur_c == 0) print_done = 1; end
      if (st_req_up) begin
        in_plat2 = 0;
        if (!no_up) up_c = pick();
        if (spur) spur_c = 1;
      end
      if (st_req_print) begin pr_c = pick(); in_plat2 = 1; end
      if (st_req_down) dn_c = pick();
      if (st_platform) begin
        dcnt++;
        if (spur && dcnt == 1 && !in_plat2) down_done = 1;
      end else begin
        dcnt = 0;
      end
      ptodown_en = force_pto || (dcnt >= dwell);
    end
  end

  // ---------------- monitor ----------------
  string         ev = "";
  int            job_n = 0, job_cyc = 0, up_cyc = 0, fault_cyc = 0, run = 0;
  int            runs[$];
  bit            pp = 0, pf = 0, busy_at_job = 0;
  logic [LW-1:0] cnt_at_job = '0;

  always @(negedge clk) begin
    if (st_req_up) begin ev = {ev, "U"}; up_cyc = cyc; end
    if (st_platform && !pp) ev = {ev, "P"};
    if (st_platform) run++;
    else if (pp) begin runs.push_back(run); run = 0; end
    if (st_req_print) ev = {ev, "R"};
    if (st_req_down) ev = {ev, "D"};
    if (job_done) begin
      ev = {ev, "J"}; job_n++; job_cyc = cyc; cnt_at_job = layer_cnt; busy_at_job = busy;
    end
    if (fault && !pf) fault_cyc = cyc;
    pp = st_platform; pf = fault;
  end

  // Reference: each layer is lift, dwell, print, dwell, descend; the job ends with one job_done.
  function automatic string exp_seq(int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, "UPRPD"};
    return {s, "J"};
  endfunction

  task automatic clear_log();
    ev = ""; runs.delete(); job_n = 0;
  endtask

  task automatic start_job(int n);
    @(negedge clk); layer_num = LW'(n); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_job(int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (job_n > 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL job_wait no job_done within %0d cycles, events %s", budget, ev); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({st_req_up, st_req_print, st_req_down, st_platform, busy, job_done, fault, layer_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got up%b pr%b dn%b pl%b busy%b jd%b f%b cnt%0d exp all 0",
               st_req_up, st_req_print, st_req_down, st_platform, busy, job_done, fault, layer_cnt);
    end
    @(negedge clk); rstn = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || ev != "") begin
      errors++; $display("FAIL reset_idle got busy %b events '%s' exp busy 0 no events", busy, ev);
    end
  endtask

  task automatic test_basic();
    resp_en = 1; dly_fix = 5; dwell = 3;
    clear_log();
    start_job(2);
    wait_job(500);
    checks++;
    if (ev != exp_seq(2)) begin errors++; $display("FAIL basic_seq got %s exp %s", ev, exp_seq(2)); end
    checks++;
    if (cnt_at_job !== LW'(2)) begin errors++; $display("FAIL basic_cnt got %0d exp 2", cnt_at_job); end
    checks++;
    if (busy_at_job !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b exp 0", busy_at_job); end
    checks++;
    if (job_cyc != down_drive_cyc + 1) begin
      errors++; $display("FAIL basic_done_lat got %0d exp %0d", job_cyc - down_drive_cyc, 1);
    end
    @(negedge clk); #1;
    checks++;
    if (job_done !== 1'b0 || layer_cnt !== LW'(2)) begin
      errors++; $display("FAIL basic_after got jd %b cnt %0d exp jd 0 cnt 2", job_done, layer_cnt);
    end
  endtask

  task automatic test_hold_ptodown();
    int n = int'($urandom_range(1, 3));
    int bad = 0;
    force_pto = 1;
    clear_log();
    start_job(n);
    wait_job(500);
    force_pto = 0;
    checks++;
    if (ev != exp_seq(n)) begin errors++; $display("FAIL hold_seq got %s exp %s", ev, exp_seq(n)); end
    checks++;
    if (runs.size() != 2 * n) begin errors++; $display("FAIL hold_dwells got %0d exp %0d", runs.size(), 2 * n); end
    foreach (runs[i]) if (runs[i] != 2) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_dwell_len got %0d dwells not 2 cycles exp 0", bad); end
  endtask

  task automatic test_abort();
    clear_log();
    start_job(3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (st_req_print) break;
    end
    abort = 1; resp_en = 0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || st_platform !== 1'b0 || layer_cnt !== '0 || job_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy %b pl %b cnt %0d jd %b exp 0 0 0 0", busy, st_platform, layer_cnt, job_done);
    end
    abort = 0; resp_en = 1;
    repeat (3) @(negedge clk); #1;
    checks++;
    if (ev != "UPR") begin errors++; $display("FAIL abort_events got %s exp UPR", ev); end
    clear_log();
    start_job(1);
    wait_job(500);
    checks++;
    if (ev != exp_seq(1) || cnt_at_job !== LW'(1)) begin
      errors++; $display("FAIL abort_rerun got %s cnt %0d exp %s cnt 1", ev, cnt_at_job, exp_seq(1));
    end
  endtask

  task automatic test_zero_and_busy_start();
    clear_log();
    start_job(0);
    #1;
    checks++;
    if (job_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_pulse got jd %b busy %b exp 1 0", job_done, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (job_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after got jd %b busy %b exp 0 0", job_done, busy);
    end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (ev != "J") begin errors++; $display("FAIL zero_events got %s exp J", ev); end
    clear_log();
    start_job(2);
    repeat (10) @(negedge clk);
    start_job(5);
    wait_job(500);
    checks++;
    if (ev != exp_seq(2) || cnt_at_job !== LW'(2)) begin
      errors++; $display("FAIL busy_start got %s cnt %0d exp %s cnt 2", ev, cnt_at_job, exp_seq(2));
    end
  endtask

  task automatic test_spurious();
    spur = 1; dly_fix = 5; dwell = 3;
    clear_log();
    start_job(1);
    wait_job(500);
    spur = 0;
    checks++;
    if (ev != exp_seq(1) || cnt_at_job !== LW'(1)) begin
      errors++; $display("FAIL spurious got %s cnt %0d exp %s cnt 1", ev, cnt_at_job, exp_seq(1));
    end
  endtask

  task automatic test_random();
    rand_dly = 1;
    for (int j = 0; j < 5; j++) begin
      int n = int'($urandom_range(1, 4));
      dwell = int'($urandom_range(1, 4));
      clear_log();
      start_job(n);
      wait_job(2000);
      checks++;
      if (ev != exp_seq(n) || cnt_at_job !== LW'(n) || fault !== 1'b0) begin
        errors++;
        $display("FAIL random_job%0d got %s cnt %0d fault %b exp %s cnt %0d fault 0",
                 j, ev, cnt_at_job, fault, exp_seq(n), n);
      end
    end
    rand_dly = 0; dwell = 3;
  endtask

  task automatic test_async_reset();
    string snap;
    clear_log();
    start_job(3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (st_platform) break;
    end
    #2 rstn = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || st_platform !== 1'b0 || layer_cnt !== '0 || st_req_up !== 1'b0) begin
      errors++; $display("FAIL areset got busy %b pl %b cnt %0d up %b exp all 0", busy, st_platform, layer_cnt, st_req_up);
    end
    resp_en = 0;
    snap = ev;
    repeat (3) @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk); #1;
    checks++;
    if (ev != snap || busy !== 1'b0) begin
      errors++; $display("FAIL areset_quiet got %s busy %b exp %s busy 0", ev, busy, snap);
    end
    resp_en = 1;
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit seen = 0;
    clear_log();
    no_up = 1;
    start_job(1);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk); #1;
      if (fault) begin seen = 1; break; end
    end
    no_up = 0;
    checks++;
    if (!seen || busy !== 1'b0 || job_n != 0) begin
      errors++; $display("FAIL tmo_fault got fault %b busy %b jobs %0d exp 1 0 0", seen, busy, job_n);
    end
    checks++;
    if (fault_cyc - up_cyc < TMO * CPU - 1 || fault_cyc - up_cyc > TMO * CPU + 1) begin
      errors++; $display("FAIL tmo_latency got %0d exp %0d", fault_cyc - up_cyc, TMO * CPU);
    end
    clear_log();
    start_job(1);
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", fault); end
    wait_job(500);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_ptodown();
    test_abort();
    test_zero_and_busy_start();
    test_spurious();
    test_random();
    test_async_reset();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/print_layer_seq.md
Name: print_layer_seq

Overview:
- Per-layer print sequencer that sits directly upstream of the platform down-control stage.
- Generates the state strobes st_req_up, st_req_print, st_req_down and the st_platform level that the down-control stage consumes.
- Consumes that stage's ptodown_en to end each platform dwell.
- Runs layer_num layers of the cycle: UP -> PLAT -> PRINT -> PLAT -> DOWN, with optional motion watchdog.

Parameters:
- CLK_PER_US, 96, clk cycles per microsecond (clk = 96 MHz).
- TMO_US, 20000, watchdog limit per motion state, in us (only with SEQ_TIMEOUT_EN).
- LAYER_W, 16, width of the layer count.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  1-cycle pulse; begin job (ignored unless IDLE)
- abort  in  1  level/pulse; return to IDLE from any state
- layer_num  in  LAYER_W  layers to print; sampled on accepted start
- up_done  in  1  lift motion complete
- print_done  in  1  head pass complete
- down_done  in  1  descent complete
- ptodown_en  in  1  dwell-complete flag from down-control stage
- st_req_up  out  1  1-cycle pulse on UP entry
- st_req_print  out  1  1-cycle pulse on PRINT entry
- st_req_down  out  1  1-cycle pulse on DOWN entry
- st_platform  out  1  high throughout both PLAT states
- busy  out  1  high when not IDLE
- layer_cnt  out  LAYER_W  layers completed in current job
- job_done  out  1  1-cycle pulse when last layer's DOWN completes
- fault  out  1  sticky watchdog fault; cleared by start

Behaviour:
- Reset values: all outputs 0; state IDLE; layer_cnt 0; latched layer_num 0.
- All outputs are registered. Strobes are asserted in the first cycle of the new state.
- States:
  - IDLE. On start with layer_num != 0: latch layer_num, clear layer_cnt and fault, go to UP. On start with layer_num == 0: stay IDLE and pulse job_done.
  - UP. On up_done, go to PLAT1.
  - PLAT1. st_platform=1. On ptodown_en, go to PRINT.
  - PRINT. On print_done, go to PLAT2.
  - PLAT2. st_platform=1. On ptodown_en, go to DOWN.
  - DOWN. On down_done: layer_cnt+1. If the new count equals the latched layer_num, pulse job_done and go to IDLE; otherwise go to UP.
- ptodown_en lags st_platform by one registered cycle. It is ignored in the first cycle of PLAT1 and of PLAT2; a stale high from the previous dwell must not advance the state.
- st_platform drops for at least one cycle (PRINT or UP) between consecutive dwells, so the downstream dwell counter clears.
- done/ptodown_en inputs arriving in a state that does not wait on them are ignored. They are not latched.
- abort has priority over all transitions. Next cycle: IDLE; strobes 0; st_platform 0. layer_cnt and fault hold. No job_done.
- start while busy: ignored.
- layer_cnt wraps never: the maximum job is 2^LAYER_W-1 layers. layer_num is captured, so later changes have no effect mid-job.
- Async reset mid-operation forces IDLE immediately; no strobes are emitted.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A us-tick counter (0..CLK_PER_US-1) plus a 15-bit us counter, cleared on every state entry, runs in UP, PRINT and DOWN.
  - Reaching TMO_US before the awaited done sets fault and forces IDLE; no job_done is pulsed.
  - PLAT states are not timed.
- SEQ_TIMEOUT_EN undefined: no counters are built; fault is tied 0.

Decomposition:
- Package print_seq_pkg holds:
  - the state enum (IDLE, UP, PLAT1, PRINT, PLAT2, DOWN);
  - CLK_PER_US;
  - the default TMO_US;
  - the LAYER_W default.
- One sub-module, seq_us_tick: free-running 1-us tick generator with synchronous clear. It is instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- layer_num=2, start; respond to each done 5 cycles after its strobe, and ptodown_en 3 cycles after st_platform rises -> strobe order per layer: up, platform, print, platform, down. job_done one cycle after the second down_done; layer_cnt=2; busy falls with it.
- Hold ptodown_en=1 continuously entering PLAT2 -> state stays in PLAT2 exactly 2 cycles minimum before DOWN. st_platform is low for ≥1 cycle between PLAT1 and PLAT2.
- abort asserted in PRINT of layer 1 of 3 -> IDLE next cycle; st_platform=0; layer_cnt=0; no job_done. A new start then re-runs from UP.
- start with layer_num=0 -> no strobes; job_done pulse 1 cycle; busy stays 0. A start while busy changes nothing.
- SEQ_TIMEOUT_EN, TMO_US=10, up_done withheld -> fault=1 and IDLE at 10*96 (±1) cycles after st_req_up. A subsequent start clears fault.
- Spurious print_done in UP and down_done in PLAT1 -> ignored; sequence completes normally with layer_cnt=1 for layer_num=1.
